multicycle_ctrl_regfile: RTL and testbench



---
 rtl/riscv_ctrl_pkg.sv | 145 ++++++++++++++
 rtl/register_file.sv | 48 ++++
 rtl/multicycle_ctrl_regfile.sv | 137 +++++++++++++
 tb/tb_multicycle_ctrl_regfile.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I controller and register file:
// FSM state enum, opcode constants, control-field encodings and the
// per-state control decode used by the main FSM.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BEQ,
        S_JAL
    } state_t;

    // Opcodes (Instr[6:0])
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // ALUOp: 11 is unused by the FSM and decodes as add
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // alu_control
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    // imm_src
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // result_src
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // alu_src_a / alu_src_b
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;
    localparam logic [1:0] SRCB_WD    = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // Moore control bundle produced by each FSM state
    typedef struct packed {
        logic       adr_src;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       pc_update;
        logic       branch;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] alu_op;
    } ctrl_t;

    // Control values asserted while the FSM sits in state s
    function automatic ctrl_t ctrl_for_state(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_ADD;
                c.result_src = RES_ALURESULT;
                c.pc_update  = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_A;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                c.result_src = RES_ALUOUT;
                c.adr_src    = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.result_src = RES_ALUOUT;
                c.adr_src    = 1'b1;
                c.mem_write  = 1'b1;
            end
            S_EXECUTER: begin
                c.alu_src_a = SRCA_A;
                c.alu_src_b = SRCB_WD;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                c.alu_src_a = SRCA_A;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a  = SRCA_A;
                c.alu_src_b  = SRCB_WD;
                c.alu_op     = ALUOP_SUB;
                c.result_src = RES_ALUOUT;
                c.branch     = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_ADD;
                c.result_src = RES_ALUOUT;
                c.pc_update  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 register file: two combinational read ports, one write port.
// x0 always reads zero. Read-during-write returns the old value.
// Optional feature macro: REGFILE_RESET_EN (reset clears every register).
module register_file
    import riscv_ctrl_pkg::*;
(
    input  logic        clk,
`ifdef REGFILE_RESET_EN
    input  logic        reset,
`endif
    input  logic        we3,
    input  logic [4:0]  a1,
    input  logic [4:0]  a2,
    input  logic [4:0]  a3,
    input  logic [31:0] wd3,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] regs_q [32];

`ifdef REGFILE_RESET_EN
    // Write port with synchronous clear of the whole array
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we3 && (a3 != 5'd0)) begin
            regs_q[a3] <= wd3;
        end
    end
`else
    // Write port; x0 is never written
    always_ff @(posedge clk) begin
        if (we3 && (a3 != 5'd0)) begin
            regs_q[a3] <= wd3;
        end
    end
`endif

    // Combinational reads with x0 forced to zero
    always_comb begin
        rd1 = (a1 == 5'd0) ? '0 : regs_q[a1];
        rd2 = (a2 == 5'd0) ? '0 : regs_q[a2];
    end

endmodule

// File: rtl/multicycle_ctrl_regfile.sv
// Control and register-file block of the multicycle RV32I core: main FSM,
// ALU decoder, immediate-source decoder and the 32x32 register file.
// Optional feature macro: REGFILE_RESET_EN (passed through to register_file).
module multicycle_ctrl_regfile
    import riscv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        zero,
    input  logic [4:0]  a1,
    input  logic [4:0]  a2,
    input  logic [4:0]  a3,
    input  logic [31:0] wd3,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic [1:0]  imm_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic        adr_src,
    output logic [2:0]  alu_control,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic        mem_write
);

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;

    // Next-state sequencing
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Control values for the state being entered; registering them keeps the
    // outputs Moore-timed with the state register
    always_comb begin
        ctrl_d = ctrl_for_state(state_d);
    end

    // State and registered control outputs; reset lands in FETCH
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
            ctrl_q  <= ctrl_for_state(S_FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // ALU decoder from ALUOp and instruction fields
    always_comb begin
        alu_control = ALU_ADD;
        case (ctrl_q.alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

    // Immediate format selected directly by opcode
    always_comb begin
        case (op)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    end

    // Output mapping; pc_write also follows zero while in BEQ
    always_comb begin
        alu_src_a  = ctrl_q.alu_src_a;
        alu_src_b  = ctrl_q.alu_src_b;
        result_src = ctrl_q.result_src;
        adr_src    = ctrl_q.adr_src;
        ir_write   = ctrl_q.ir_write;
        reg_write  = ctrl_q.reg_write;
        mem_write  = ctrl_q.mem_write;
        pc_write   = ctrl_q.pc_update | (ctrl_q.branch & zero);
    end

    register_file u_register_file (
        .clk   (clk),
`ifdef REGFILE_RESET_EN
        .reset (reset),
`endif
        .we3   (reg_write),
        .a1    (a1),
        .a2    (a2),
        .a3    (a3),
        .wd3   (wd3),
        .rd1   (rd1),
        .rd2   (rd2)
    );

endmodule

// File: tb/tb_multicycle_ctrl_regfile.sv
// Randomized self-checking bench for multicycle_ctrl_regfile. Expected
// control outputs come from per-opcode phase sequences and the documented
// per-phase output table; register reads come from an array model.
module tb_multicycle_ctrl_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        zero;
    logic [4:0]  a1, a2, a3;
    logic [31:0] wd3;
    logic [31:0] rd1, rd2;
    logic [1:0]  imm_src, alu_src_a, alu_src_b, result_src;
    logic        adr_src;
    logic [2:0]  alu_control;
    logic        ir_write, pc_write, reg_write, mem_write;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [31:0] model_regs [32];
    bit          model_valid [32];

    // Phase codes of the reference model
    localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MW = 4, P_MWR = 5,
                   P_ER = 6, P_EI = 7, P_AW = 8, P_B = 9, P_J = 10;

    always #5 clk = ~clk;

    multicycle_ctrl_regfile dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .zero        (zero),
        .a1          (a1),
        .a2          (a2),
        .a3          (a3),
        .wd3         (wd3),
        .rd1         (rd1),
        .rd2         (rd2),
        .imm_src     (imm_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .result_src  (result_src),
        .adr_src     (adr_src),
        .alu_control (alu_control),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .reg_write   (reg_write),
        .mem_write   (mem_write)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t op=%b f3=%b)", tag, got, exp, $time, op, funct3);
        end
    endtask

    // Expected {ir,pcw,rw,mw,adr,srcA,srcB,res,imm,aluc}
    function automatic logic [15:0] expected(input int ph, input logic [6:0] o,
                                             input logic [2:0] f3, input logic f7, input logic z);
        logic       ir = 0, upd = 0, br = 0, rw = 0, mw = 0, adr = 0;
        logic [1:0] sa = 0, sb = 0, res = 0, aop = 0, imm;
        logic [2:0] ac;
        case (ph)
            P_F:   begin ir = 1; sb = 2'b10; res = 2'b10; upd = 1; end
            P_D:   begin sa = 2'b01; sb = 2'b01; end
            P_MA:  begin sa = 2'b10; sb = 2'b01; end
            P_MR:  begin adr = 1; end
            P_MW:  begin res = 2'b01; rw = 1; end
            P_MWR: begin adr = 1; mw = 1; end
            P_ER:  begin sa = 2'b10; aop = 2'b10; end
            P_EI:  begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
            P_AW:  begin rw = 1; end
            P_B:   begin sa = 2'b10; aop = 2'b01; br = 1; end
            P_J:   begin sa = 2'b01; sb = 2'b10; upd = 1; end
            default: ;
        endcase
        if (aop == 2'b01) ac = 3'b001;
        else if (aop != 2'b10) ac = 3'b000;
        else case (f3)
            3'b000: ac = (o[5] && f7) ? 3'b001 : 3'b000;
            3'b010: ac = 3'b101;
            3'b100: ac = 3'b100;
            3'b110: ac = 3'b011;
            3'b111: ac = 3'b010;
            3'b001: ac = 3'b110;
            3'b101: ac = 3'b111;
            default: ac = 3'b000;
        endcase
        if (o == 7'b0100011) imm = 2'b01;
        else if (o == 7'b1100011) imm = 2'b10;
        else if (o == 7'b1101111) imm = 2'b11;
        else imm = 2'b00;
        return {ir, upd | (br & z), rw, mw, adr, sa, sb, res, imm, ac};
    endfunction

    function automatic logic [31:0] observed();
        return {16'h0, ir_write, pc_write, reg_write, mem_write, adr_src,
                alu_src_a, alu_src_b, result_src, imm_src, alu_control};
    endfunction

    function automatic logic [4:0] pick_addr();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
`ifdef REGFILE_RESET_EN
            model_valid[i] = 1'b1;
            model_regs[i]  = '0;
`else
            model_valid[i] = (i == 0);
            model_regs[i]  = '0;
`endif
        end
    endtask

    // One cycle: randomize datapath-side inputs, check at negedge, commit write
    task automatic cycle(input int ph, input string tag);
        logic [15:0] e;
        zero = 1'($urandom);
        a1   = pick_addr();
        a2   = pick_addr();
        a3   = ($urandom_range(0, 4) == 0) ? 5'd0 : pick_addr();
        wd3  = $urandom;
        @(negedge clk);
        e = expected(ph, op, funct3, funct7b5, zero);
        check(tag, observed(), {16'h0, e});
        if (model_valid[a1]) check("rd1", rd1, model_regs[a1]);
        if (model_valid[a2]) check("rd2", rd2, model_regs[a2]);
        if (e[13] && reset && a3 != 5'd0) begin
            model_regs[a3]  = wd3;
            model_valid[a3] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [6:0] o);
        int seq[$];
        op       = o;
        funct3   = 3'($urandom);
        funct7b5 = 1'($urandom);
        case (o)
            7'b0000011: seq = '{P_F, P_D, P_MA, P_MR, P_MW};
            7'b0100011: seq = '{P_F, P_D, P_MA, P_MWR};
            7'b0110011: seq = '{P_F, P_D, P_ER, P_AW};
            7'b0010011: seq = '{P_F, P_D, P_EI, P_AW};
            7'b1100011: seq = '{P_F, P_D, P_B};
            7'b1101111: seq = '{P_F, P_D, P_J, P_AW};
            default:    seq = '{P_F, P_D};
        endcase
        foreach (seq[i]) cycle(seq[i], $sformatf("ctrl_op%b_step%0d", o, i));
    endtask

    function automatic logic [6:0] pick_op();
        logic [6:0] o;
        case ($urandom_range(0, 6))
            0: o = 7'b0000011;
            1: o = 7'b0100011;
            2: o = 7'b0110011;
            3: o = 7'b0010011;
            4: o = 7'b1100011;
            5: o = 7'b1101111;
            default: begin
                o = 7'($urandom);
                if (o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
                    o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111)
                    o = 7'b0000000;
            end
        endcase
        return o;
    endfunction

    initial begin
        reset = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0;
        a1 = '0; a2 = '0; a3 = '0; wd3 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        cycle(P_F, "reset_state");
        reset = 1'b1;

        // Directed register-file case: x3 <- 25 via R-type writeback, then read
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
        cycle(P_F, "dir_fetch");
        cycle(P_D, "dir_decode");
        cycle(P_ER, "dir_exec_sub");
        zero = 1'b0; a1 = 5'd3; a2 = 5'd0; a3 = 5'd3; wd3 = 32'd25;
        @(negedge clk);
        check("dir_aluwb", observed(), {16'h0, expected(P_AW, op, funct3, funct7b5, zero)});
        model_regs[3] = 32'd25; model_valid[3] = 1'b1;
        @(posedge clk); #1;
        a1 = 5'd3; a3 = 5'd0; op = 7'b1111111;
        @(negedge clk);
        check("x3_reads_25", rd1, 32'd25);
        check("dir_fetch2", observed(), {16'h0, expected(P_F, op, funct3, funct7b5, zero)});
        @(posedge clk); #1;
        cycle(P_D, "dir_nop_decode");

        for (int n = 0; n < 250; n++) run_instr(pick_op());

        // Reset in the middle of a lw abandons it
        op = 7'b0000011;
        cycle(P_F, "mid_fetch");
        cycle(P_D, "mid_decode");
        reset = 1'b0;
        cycle(P_MA, "mid_memadr");
        reset = 1'b1;
`ifdef REGFILE_RESET_EN
        model_reset();
`endif
        cycle(P_F, "after_reset_fetch");
        cycle(P_D, "after_reset_decode");
        cycle(P_MA, "after_reset_memadr");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
